mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameters SHALL be: ADDR_W, default 16, line-index width (PC_BITS-4); LINE_W, default 128, cache-line width; STARVE_LIMIT, default 4, the number of I-side wait cycles that forces an I grant.
REQ-002 The module SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 The I-side ports SHALL be:
- Ic_mem_req  in  1  I-cache line request, level, held until F_mem_valid.
- Ic_mem_addr  in  ADDR_W  I line index.
- F_mem_inst  out  LINE_W  returned instruction line.
- F_mem_valid  out  1  one-cycle I response strobe.
REQ-004 The D-read ports SHALL be:
- Dc_mem_req  in  1  D-cache refill request, level, held until MEM_mem_valid.
- Dc_mem_addr  in  ADDR_W  D line index.
- MEM_data_line  out  LINE_W  returned data line.
- MEM_mem_valid  out  1  one-cycle D response strobe.
REQ-005 The D-writeback ports SHALL be:
- Dc_wb_we  in  1  one-cycle dirty-line eviction pulse.
- Dc_wb_addr  in  ADDR_W  writeback line index.
- Dc_wb_wline  in  LINE_W  writeback line data.
REQ-006 The backing-memory ports SHALL be:
- M_req  out  1  request, held until M_ack.
- M_we  out  1  write=1, read=0.
- M_addr  out  ADDR_W  line index.
- M_wline  out  LINE_W  write data.
- M_rline  in  LINE_W  read data, valid with M_ack.
- M_ack  in  1  one-cycle completion.
- wb_ovf  out  1  sticky protocol-error flag.

Function
REQ-007 A one-entry writeback buffer (wb_vld, wb_addr, wb_line) SHALL capture Dc_wb_addr and Dc_wb_wline on any cycle with Dc_wb_we=1 and wb_vld=0.
REQ-008 A Dc_wb_we pulse with wb_vld=1 SHALL be dropped and SHALL set wb_ovf=1 until reset.
- This applies even if the buffer drains in the same cycle.
REQ-009 The FSM SHALL have the states IDLE, BUSY and RESP.
- Only IDLE grants.
- Exactly one backing transaction SHALL be outstanding at a time.
REQ-010 Grant priority in IDLE SHALL be as follows:
- (1) wb_vld.
- (2) Ic_mem_req when starve_cnt >= STARVE_LIMIT.
- (3) Dc_mem_req.
- (4) Ic_mem_req.
REQ-011 A granted writeback SHALL go to BUSY with M_req=1, M_we=1, M_addr=wb_addr and M_wline=wb_line.
- On M_ack, wb_vld SHALL clear and the FSM SHALL return to IDLE.
- There SHALL be no RESP and no requester strobe.
REQ-012 A granted read SHALL latch the requester ID and address, then go to BUSY with M_req=1 and M_we=0.
- On M_ack, M_rline SHALL be registered and the FSM SHALL go to RESP.
REQ-013 In RESP, the arbiter SHALL assert exactly one of F_mem_valid or MEM_mem_valid for one cycle with the registered line, then go to IDLE.
REQ-014 Response latency SHALL be: the grant cycle, plus the cycles until M_ack, plus 1.
- With a combinational M_ack in the first BUSY cycle, the strobe appears 2 cycles after grant.
REQ-015 A requester SHALL deassert its request in the cycle after its strobe; the arbiter SHALL NOT re-grant a requester during RESP.
REQ-016 M_req, M_we, M_addr and M_wline SHALL be stable from the grant until M_ack; M_req SHALL drop in the cycle after M_ack.
REQ-017 starve_cnt (saturating, width clog2(STARVE_LIMIT)+1) SHALL follow these rules:
- Increment on each IDLE grant to a non-I source while Ic_mem_req=1.
- Clear on an I grant or when Ic_mem_req=0.
REQ-018 A D read whose address equals wb_addr while wb_vld=1 SHALL never be served before that writeback completes; rule (1) guarantees this.
REQ-019 An M_ack outside BUSY SHALL be ignored.
REQ-020 F_mem_inst and MEM_data_line SHALL hold their last value outside strobes.

Reset
REQ-021 With rst=1 at a clock edge, the following SHALL hold:
- state=IDLE; wb_vld=0; starve_cnt=0; wb_ovf=0.
- M_req=0; M_we=0; F_mem_valid=0; MEM_mem_valid=0.
- M_addr, M_wline, F_mem_inst and MEM_data_line SHALL be all-zero.
REQ-022 A reset asserted in BUSY SHALL abandon the transaction.
- An M_ack arriving after reset SHALL be ignored (REQ-019).
- A captured writeback SHALL be lost.

Verification
REQ-023 I only: Ic_mem_req=1, addr=0x0012; M_ack 3 cycles after M_req with M_rline=0xA5..A5 -> M_addr=0x0012, M_we=0; F_mem_valid for 1 cycle carrying 0xA5..A5; MEM_mem_valid stays 0.
REQ-024 Simultaneous I and D requests in IDLE (starve_cnt=0) -> D granted first, MEM_mem_valid, then I granted, F_mem_valid; starve_cnt reaches 1 and then clears.
REQ-025 Dc_wb_we pulse (addr 0x0040, line L1) in the same cycle as Dc_mem_req (addr 0x0040) -> write M_we=1 with addr 0x0040 and data L1 issued first; the read is issued only after its M_ack; no strobe for the write.
REQ-026 Dc_mem_req held high with back-to-back D re-requests while Ic_mem_req=1, STARVE_LIMIT=4 -> after 4 D grants, the next grant is I.
REQ-027 A second Dc_wb_we pulse while wb_vld=1 -> wb_ovf=1 and stays 1; the first buffered line is written unchanged.
REQ-028 rst=1 for 1 cycle while BUSY, then a late M_ack -> all outputs at REQ-021 values; no strobe; next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache reads, D-cache reads and D-cache writebacks onto a single
// backing-memory port with one transaction outstanding at a time.
module mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int LINE_W       = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Ic_mem_req,
   input  logic [ADDR_W-1:0] Ic_mem_addr,
   output logic [LINE_W-1:0] F_mem_inst,
   output logic              F_mem_valid,
   input  logic              Dc_mem_req,
   input  logic [ADDR_W-1:0] Dc_mem_addr,
   output logic [LINE_W-1:0] MEM_data_line,
   output logic              MEM_mem_valid,
   input  logic              Dc_wb_we,
   input  logic [ADDR_W-1:0] Dc_wb_addr,
   input  logic [LINE_W-1:0] Dc_wb_wline,
   output logic              M_req,
   output logic              M_we,
   output logic [ADDR_W-1:0] M_addr,
   output logic [LINE_W-1:0] M_wline,
   input  logic [LINE_W-1:0] M_rline,
   input  logic              M_ack,
   output logic              wb_ovf
);

   localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state_q;
   logic                wbVld_q;
   logic [ADDR_W-1:0]   wbAddr_q;
   logic [LINE_W-1:0]   wbLine_q;
   logic                wbOvf_q;
   logic [CNT_W-1:0]    starveCnt_q;
   logic                isWrite_q;
   logic                isInst_q;
   logic                mReq_q;
   logic                mWe_q;
   logic [ADDR_W-1:0]   mAddr_q;
   logic [LINE_W-1:0]   mWline_q;
   logic                fValid_q;
   logic                memValid_q;
   logic [LINE_W-1:0]   fInst_q;
   logic [LINE_W-1:0]   memLine_q;

   logic                wbCapture;
   logic                wbPending;
   logic                starved;
   logic                gntWb;
   logic                gntI;
   logic                gntD;
   logic [ADDR_W-1:0]   wbGntAddr;
   logic [LINE_W-1:0]   wbGntLine;

   // A writeback arriving this cycle counts as pending so that a same-cycle
   // D read of the same line can never overtake it.
   always_comb begin
      wbCapture = Dc_wb_we && !wbVld_q;
      wbPending = wbVld_q || wbCapture;
      wbGntAddr = wbVld_q ? wbAddr_q : Dc_wb_addr;
      wbGntLine = wbVld_q ? wbLine_q : Dc_wb_wline;
      starved   = starveCnt_q >= LIMIT;
      gntWb     = (state_q == IDLE) && wbPending;
      gntI      = (state_q == IDLE) && !wbPending && Ic_mem_req && (starved || !Dc_mem_req);
      gntD      = (state_q == IDLE) && !wbPending && Dc_mem_req && !gntI;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wbVld_q     <= 1'b0;
         wbAddr_q    <= '0;
         wbLine_q    <= '0;
         wbOvf_q     <= 1'b0;
         starveCnt_q <= '0;
         isWrite_q   <= 1'b0;
         isInst_q    <= 1'b0;
         mReq_q      <= 1'b0;
         mWe_q       <= 1'b0;
         mAddr_q     <= '0;
         mWline_q    <= '0;
         fValid_q    <= 1'b0;
         memValid_q  <= 1'b0;
         fInst_q     <= '0;
         memLine_q   <= '0;
      end else begin
         if (wbCapture) begin
            wbVld_q  <= 1'b1;
            wbAddr_q <= Dc_wb_addr;
            wbLine_q <= Dc_wb_wline;
         end
         if (Dc_wb_we && wbVld_q) begin
            wbOvf_q <= 1'b1;
         end

         if (!Ic_mem_req || gntI) begin
            starveCnt_q <= '0;
         end else if ((gntWb || gntD) && starveCnt_q != '1) begin
            starveCnt_q <= starveCnt_q + CNT_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (gntWb) begin
                  mReq_q    <= 1'b1;
                  mWe_q     <= 1'b1;
                  mAddr_q   <= wbGntAddr;
                  mWline_q  <= wbGntLine;
                  isWrite_q <= 1'b1;
                  state_q   <= BUSY;
               end else if (gntI || gntD) begin
                  mReq_q    <= 1'b1;
                  mWe_q     <= 1'b0;
                  mAddr_q   <= gntI ? Ic_mem_addr : Dc_mem_addr;
                  isWrite_q <= 1'b0;
                  isInst_q  <= gntI;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               if (M_ack) begin
                  mReq_q <= 1'b0;
                  if (isWrite_q) begin
                     wbVld_q <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     if (isInst_q) begin
                        fInst_q  <= M_rline;
                        fValid_q <= 1'b1;
                     end else begin
                        memLine_q  <= M_rline;
                        memValid_q <= 1'b1;
                     end
                     state_q <= RESP;
                  end
               end
            end
            RESP: begin
               fValid_q   <= 1'b0;
               memValid_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign M_req         = mReq_q;
   assign M_we          = mWe_q;
   assign M_addr        = mAddr_q;
   assign M_wline       = mWline_q;
   assign F_mem_valid   = fValid_q;
   assign F_mem_inst    = fInst_q;
   assign MEM_mem_valid = memValid_q;
   assign MEM_data_line = memLine_q;
   assign wb_ovf        = wbOvf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester agents, a latency-programmable backing
// memory, and a line-level reference memory that predicts every returned line.
module tb_mem_arbiter;

   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;
   localparam int STARVE = 4;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [LINE_W-1:0] line_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  Ic_mem_req, Dc_mem_req, Dc_wb_we, M_ack;
   addr_t Ic_mem_addr, Dc_mem_addr, Dc_wb_addr;
   line_t Dc_wb_wline, M_rline;
   logic  F_mem_valid, MEM_mem_valid, M_req, M_we, wb_ovf;
   line_t F_mem_inst, MEM_data_line, M_wline;
   addr_t M_addr;

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    strobeCnt = 0;
   int    stabErr = 0;
   int    dropErr = 0;
   int    bothErr = 0;
   int    ackLat = 0;
   bit    forceAck = 0;
   bit    pause = 0;
   bit    dHold = 0;

   addr_t iAddrQ[$], dAddrQ[$], wbAddrQ[$];
   line_t wbLineQ[$];
   line_t fDataQ[$], dDataQ[$];
   bit    txWe[$];
   addr_t txAddr[$];
   line_t txLine[$];
   int    latQ[$];
   byte   evQ[$];
   line_t memArr[addr_t];
   line_t refMem[addr_t];

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE)) dut (
      .clk(clk), .rst(rst),
      .Ic_mem_req(Ic_mem_req), .Ic_mem_addr(Ic_mem_addr),
      .F_mem_inst(F_mem_inst), .F_mem_valid(F_mem_valid),
      .Dc_mem_req(Dc_mem_req), .Dc_mem_addr(Dc_mem_addr),
      .MEM_data_line(MEM_data_line), .MEM_mem_valid(MEM_mem_valid),
      .Dc_wb_we(Dc_wb_we), .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline),
      .M_req(M_req), .M_we(M_we), .M_addr(M_addr), .M_wline(M_wline),
      .M_rline(M_rline), .M_ack(M_ack), .wb_ovf(wb_ovf)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   // Default contents of a never-written line.
   function automatic line_t lineOf(input addr_t a);
      return {a, ~a, a ^ 16'h5A5A, ~(a ^ 16'h5A5A), a, ~a, a + 16'd1, ~a};
   endfunction

   function automatic line_t refRead(input addr_t a);
      if (refMem.exists(a)) return refMem[a];
      return lineOf(a);
   endfunction

   task automatic clearLogs();
      fDataQ.delete(); dDataQ.delete(); txWe.delete(); txAddr.delete();
      txLine.delete(); latQ.delete(); evQ.delete();
   endtask

   // Requesters: hold a request until its strobe, drop it in the next cycle;
   // with dHold the D side re-requests without dropping. Writebacks go out
   // as one-cycle pulses, one per cycle.
   initial begin
      bit iDrop, dDrop;
      iDrop = 0; dDrop = 0;
      Ic_mem_req = 0; Ic_mem_addr = '0; Dc_mem_req = 0; Dc_mem_addr = '0;
      Dc_wb_we = 0; Dc_wb_addr = '0; Dc_wb_wline = '0;
      forever begin
         @(posedge clk); #1;
         Dc_wb_we = 0;
         if (rst || pause) begin
            Ic_mem_req = 0; Dc_mem_req = 0; iDrop = 0; dDrop = 0;
         end else begin
            if (F_mem_valid) iDrop = 1;
            else if (iDrop) begin
               iDrop = 0; void'(iAddrQ.pop_front()); Ic_mem_req = 0;
            end else if (!Ic_mem_req && iAddrQ.size() > 0) begin
               Ic_mem_req = 1; Ic_mem_addr = iAddrQ[0];
            end
            if (MEM_mem_valid) dDrop = 1;
            else if (dDrop) begin
               dDrop = 0; void'(dAddrQ.pop_front());
               if (dHold && dAddrQ.size() > 0) Dc_mem_addr = dAddrQ[0];
               else Dc_mem_req = 0;
            end else if (!Dc_mem_req && dAddrQ.size() > 0) begin
               Dc_mem_req = 1; Dc_mem_addr = dAddrQ[0];
            end
            if (wbAddrQ.size() > 0) begin
               Dc_wb_we = 1; Dc_wb_addr = wbAddrQ.pop_front(); Dc_wb_wline = wbLineQ.pop_front();
            end
         end
      end
   end

   // Backing memory: acks ackLat cycles after seeing M_req, logs each transaction.
   initial begin
      int busyCnt;
      busyCnt = 0; M_ack = 0; M_rline = '0;
      forever begin
         @(posedge clk); #1;
         if (M_ack) M_ack = 0;
         else if (forceAck) begin
            M_ack = 1; M_rline = {16{8'h3C}}; forceAck = 0;
         end else if (M_req === 1'b1) begin
            if (busyCnt >= ackLat) begin
               M_ack = 1; busyCnt = 0;
               txWe.push_back(M_we); txAddr.push_back(M_addr); txLine.push_back(M_wline);
               if (M_we) memArr[M_addr] = M_wline;
               else M_rline = memArr.exists(M_addr) ? memArr[M_addr] : lineOf(M_addr);
            end else busyCnt++;
         end else busyCnt = 0;
      end
   end

   // Observes strobes and the memory-port handshake away from the clock edge.
   initial begin
      bit inTx, ackSeen;
      int riseCyc;
      logic sWe; addr_t sAddr; line_t sLine;
      inTx = 0; ackSeen = 0; riseCyc = 0;
      forever begin
         @(negedge clk);
         if (F_mem_valid === 1'b1) begin
            fDataQ.push_back(F_mem_inst); evQ.push_back("I"); latQ.push_back(cyc - riseCyc); strobeCnt++;
         end
         if (MEM_mem_valid === 1'b1) begin
            dDataQ.push_back(MEM_data_line); evQ.push_back("D"); latQ.push_back(cyc - riseCyc); strobeCnt++;
         end
         if (F_mem_valid === 1'b1 && MEM_mem_valid === 1'b1) bothErr++;
         if (M_req === 1'b1) begin
            if (!inTx) begin
               inTx = 1; riseCyc = cyc; sWe = M_we; sAddr = M_addr; sLine = M_wline;
            end else if (M_we !== sWe || M_addr !== sAddr || M_wline !== sLine) stabErr++;
            if (ackSeen) dropErr++;
         end else inTx = 0;
         ackSeen = (M_ack === 1'b1);
      end
   end

   task automatic waitStrobes(input int target, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (strobeCnt >= target) ok = 1;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if ({M_req, M_we, F_mem_valid, MEM_mem_valid, wb_ovf} !== 5'b0) begin
         failures++; $display("[TB] FAIL reset_ctrl got=%b exp=00000", {M_req, M_we, F_mem_valid, MEM_mem_valid, wb_ovf}); end
      checks++; if (M_addr !== '0 || M_wline !== '0) begin
         failures++; $display("[TB] FAIL reset_mport addr=%h wline=%h exp=0", M_addr, M_wline); end
      checks++; if (F_mem_inst !== '0 || MEM_data_line !== '0) begin
         failures++; $display("[TB] FAIL reset_lines f=%h d=%h exp=0", F_mem_inst, MEM_data_line); end
      rst = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_inst_only();
      int base; bit ok;
      clearLogs(); ackLat = 3;
      memArr[16'h0012] = {16{8'hA5}}; refMem[16'h0012] = {16{8'hA5}};
      base = strobeCnt;
      iAddrQ.push_back(16'h0012);
      waitStrobes(base + 1, 60, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL inst_timeout strobes=%0d exp=%0d", strobeCnt, base + 1); end
      checks++; if (txAddr.size() !== 1 || txAddr[0] !== 16'h0012 || txWe[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL inst_mport n=%0d addr=%h we=%b exp 1/0012/0", txAddr.size(), txAddr[0], txWe[0]); end
      checks++; if (fDataQ.size() !== 1 || fDataQ[0] !== {16{8'hA5}}) begin
         failures++; $display("[TB] FAIL inst_data n=%0d got=%h exp=a5..a5", fDataQ.size(), fDataQ[0]); end
      checks++; if (dDataQ.size() !== 0) begin failures++; $display("[TB] FAIL inst_no_dstrobe got=%0d exp=0", dDataQ.size()); end
      checks++; if (latQ[0] !== ackLat + 1) begin failures++; $display("[TB] FAIL inst_latency got=%0d exp=%0d", latQ[0], ackLat + 1); end
   endtask

   task automatic test_simultaneous();
      int base; bit ok;
      clearLogs(); ackLat = 0;
      base = strobeCnt;
      iAddrQ.push_back(16'h0300); dAddrQ.push_back(16'h0301);
      waitStrobes(base + 2, 60, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL simul_timeout strobes=%0d exp=%0d", strobeCnt, base + 2); end
      checks++; if (evQ.size() !== 2 || evQ[0] !== "D" || evQ[1] !== "I") begin
         failures++; $display("[TB] FAIL simul_order n=%0d first=%c second=%c exp D,I", evQ.size(), evQ[0], evQ[1]); end
      checks++; if (txAddr.size() !== 2 || txAddr[0] !== 16'h0301 || txAddr[1] !== 16'h0300) begin
         failures++; $display("[TB] FAIL simul_mport n=%0d a0=%h a1=%h exp 0301,0300", txAddr.size(), txAddr[0], txAddr[1]); end
      checks++; if (dDataQ[0] !== refRead(16'h0301) || fDataQ[0] !== refRead(16'h0300)) begin
         failures++; $display("[TB] FAIL simul_data d=%h f=%h", dDataQ[0], fDataQ[0]); end
      checks++; if (latQ[0] !== 1) begin failures++; $display("[TB] FAIL simul_latency got=%0d exp=1", latQ[0]); end
   endtask

   task automatic test_wb_before_read();
      int base; bit ok; line_t l1;
      clearLogs(); ackLat = 1;
      l1 = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
      refMem[16'h0040] = l1;
      base = strobeCnt;
      wbAddrQ.push_back(16'h0040); wbLineQ.push_back(l1); dAddrQ.push_back(16'h0040);
      waitStrobes(base + 1, 60, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL wbrd_timeout strobes=%0d exp=%0d", strobeCnt, base + 1); end
      checks++; if (txWe.size() !== 2 || txWe[0] !== 1'b1 || txAddr[0] !== 16'h0040 || txLine[0] !== l1) begin
         failures++; $display("[TB] FAIL wbrd_write n=%0d we=%b addr=%h line=%h exp 2/1/0040/%h", txWe.size(), txWe[0], txAddr[0], txLine[0], l1); end
      checks++; if (txWe[1] !== 1'b0 || txAddr[1] !== 16'h0040) begin
         failures++; $display("[TB] FAIL wbrd_read we=%b addr=%h exp 0/0040", txWe[1], txAddr[1]); end
      checks++; if (strobeCnt !== base + 1 || dDataQ.size() !== 1 || dDataQ[0] !== l1) begin
         failures++; $display("[TB] FAIL wbrd_data strobes=%0d got=%h exp=%0d/%h", strobeCnt - base, dDataQ[0], 1, l1); end
   endtask

   task automatic test_starvation();
      int base; bit ok; int cnt; int dLeft; bit iWait; addr_t expSeq[$];
      clearLogs(); ackLat = 0; dHold = 1;
      for (int k = 0; k < 6; k++) dAddrQ.push_back(addr_t'(16'h0100 + k));
      iAddrQ.push_back(16'h0200);
      cnt = 0; dLeft = 6; iWait = 1;
      while (iWait || dLeft > 0) begin
         if (iWait && (cnt >= STARVE || dLeft == 0)) begin
            expSeq.push_back(16'h0200); iWait = 0; cnt = 0;
         end else begin
            expSeq.push_back(addr_t'(16'h0100 + 6 - dLeft)); dLeft--;
            if (iWait) cnt++;
         end
      end
      base = strobeCnt;
      waitStrobes(base + 7, 200, ok);
      dHold = 0;
      checks++; if (!ok) begin failures++; $display("[TB] FAIL starve_timeout strobes=%0d exp=%0d", strobeCnt, base + 7); end
      checks++; if (txAddr.size() !== expSeq.size()) begin
         failures++; $display("[TB] FAIL starve_count got=%0d exp=%0d", txAddr.size(), expSeq.size()); end
      for (int k = 0; k < expSeq.size() && k < txAddr.size(); k++) begin
         checks++; if (txAddr[k] !== expSeq[k]) begin
            failures++; $display("[TB] FAIL starve_grant%0d got=%h exp=%h", k, txAddr[k], expSeq[k]); end
      end
   endtask

   task automatic test_wb_overflow();
      int base; bit ok; line_t l2, l3;
      clearLogs(); ackLat = 2;
      l2 = {4{32'h22224444}}; l3 = {4{32'h33336666}};
      refMem[16'h0050] = l2;
      base = strobeCnt;
      wbAddrQ.push_back(16'h0050); wbLineQ.push_back(l2);
      wbAddrQ.push_back(16'h0051); wbLineQ.push_back(l3);
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); if (txWe.size() >= 1) ok = 1; end
      repeat (5) @(negedge clk);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL ovf_timeout writes=%0d exp=1", txWe.size()); end
      checks++; if (txWe.size() !== 1 || txWe[0] !== 1'b1 || txAddr[0] !== 16'h0050 || txLine[0] !== l2) begin
         failures++; $display("[TB] FAIL ovf_write n=%0d addr=%h line=%h exp 1/0050/%h", txWe.size(), txAddr[0], txLine[0], l2); end
      checks++; if (wb_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", wb_ovf); end
      checks++; if (strobeCnt !== base) begin failures++; $display("[TB] FAIL ovf_no_strobe got=%0d exp=0", strobeCnt - base); end
      dAddrQ.push_back(16'h0051);
      waitStrobes(base + 1, 60, ok);
      checks++; if (dDataQ.size() !== 1 || dDataQ[0] !== refRead(16'h0051)) begin
         failures++; $display("[TB] FAIL ovf_dropped_line n=%0d got=%h exp=%h", dDataQ.size(), dDataQ[0], refRead(16'h0051)); end
      checks++; if (wb_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%b exp=1", wb_ovf); end
   endtask

   task automatic test_reset_in_busy();
      int base; bit ok;
      clearLogs(); ackLat = 1000;
      iAddrQ.push_back(16'h0077);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); if (M_req === 1'b1) ok = 1; end
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rstbusy_no_req got=%b exp=1", M_req); end
      rst = 1; pause = 1;
      @(negedge clk);
      rst = 0;
      checks++; if ({M_req, M_we, F_mem_valid, MEM_mem_valid, wb_ovf} !== 5'b0) begin
         failures++; $display("[TB] FAIL rstbusy_ctrl got=%b exp=00000", {M_req, M_we, F_mem_valid, MEM_mem_valid, wb_ovf}); end
      checks++; if (M_addr !== '0 || M_wline !== '0 || F_mem_inst !== '0 || MEM_data_line !== '0) begin
         failures++; $display("[TB] FAIL rstbusy_data addr=%h wline=%h f=%h d=%h exp=0", M_addr, M_wline, F_mem_inst, MEM_data_line); end
      base = strobeCnt;
      forceAck = 1;
      repeat (5) @(negedge clk);
      checks++; if (strobeCnt !== base || M_req !== 1'b0) begin
         failures++; $display("[TB] FAIL rstbusy_late_ack strobes=%0d req=%b exp 0/0", strobeCnt - base, M_req); end
      ackLat = 2; pause = 0;
      waitStrobes(base + 1, 60, ok);
      checks++; if (!ok || fDataQ.size() !== 1 || fDataQ[0] !== refRead(16'h0077)) begin
         failures++; $display("[TB] FAIL rstbusy_resume n=%0d got=%h exp=%h", fDataQ.size(), fDataQ[0], refRead(16'h0077)); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 15; it++) begin
         int nI, nD, base; bit doWb, ok; addr_t a; line_t l; line_t iExp[$], dExp[$];
         clearLogs();
         ackLat = $urandom_range(0, 3);
         nI = $urandom_range(0, 2); nD = $urandom_range(0, 2); doWb = 1'($urandom_range(0, 1));
         if (nI + nD + int'(doWb) == 0) nD = 1;
         base = strobeCnt;
         if (doWb) begin
            a = addr_t'(16'h0040 + $urandom_range(0, 7));
            l = {$urandom, $urandom, $urandom, $urandom};
            refMem[a] = l;
            wbAddrQ.push_back(a); wbLineQ.push_back(l);
            dAddrQ.push_back(a); dExp.push_back(l);
         end
         for (int k = 0; k < nI; k++) begin
            a = addr_t'(16'h0040 + $urandom_range(0, 15)); iAddrQ.push_back(a); iExp.push_back(refRead(a));
         end
         for (int k = 0; k < nD; k++) begin
            a = addr_t'(16'h0040 + $urandom_range(0, 15)); dAddrQ.push_back(a); dExp.push_back(refRead(a));
         end
         waitStrobes(base + nI + nD + int'(doWb), 200, ok);
         checks++; if (!ok || fDataQ.size() !== iExp.size() || dDataQ.size() !== dExp.size()) begin
            failures++; $display("[TB] FAIL rand%0d_counts i=%0d/%0d d=%0d/%0d", it, fDataQ.size(), iExp.size(), dDataQ.size(), dExp.size()); end
         for (int k = 0; k < iExp.size() && k < fDataQ.size(); k++) begin
            checks++; if (fDataQ[k] !== iExp[k]) begin failures++; $display("[TB] FAIL rand%0d_i%0d got=%h exp=%h", it, k, fDataQ[k], iExp[k]); end
         end
         for (int k = 0; k < dExp.size() && k < dDataQ.size(); k++) begin
            checks++; if (dDataQ[k] !== dExp[k]) begin failures++; $display("[TB] FAIL rand%0d_d%0d got=%h exp=%h", it, k, dDataQ[k], dExp[k]); end
         end
      end
      checks++; if (wb_ovf !== 1'b0) begin failures++; $display("[TB] FAIL rand_ovf got=%b exp=0", wb_ovf); end
   endtask

   task automatic test_protocol();
      checks++; if (stabErr !== 0) begin failures++; $display("[TB] FAIL mport_stable got=%0d exp=0", stabErr); end
      checks++; if (dropErr !== 0) begin failures++; $display("[TB] FAIL mreq_drop got=%0d exp=0", dropErr); end
      checks++; if (bothErr !== 0) begin failures++; $display("[TB] FAIL dual_strobe got=%0d exp=0", bothErr); end
   endtask

   initial begin
      test_reset();
      test_inst_only();
      test_simultaneous();
      test_wb_before_read();
      test_starvation();
      test_wb_overflow();
      test_reset_in_busy();
      test_random();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
